ita_requant_ctrl: RTL and testbench

- Sequences the ITA requantizer datapath for one tile of output beats at a time.
- Holds a per-stage table of requantization constants (mode, eps_mult, right_shift) and latches one entry per tile request.
- Drives the requantizer's calc_en / calc_en_q enables and produces an out_valid/out_last pair aligned with the requantizer output.
- The requantizer itself cannot stall, so downstream backpressure is enforced with credits.

---
 rtl/ita_requant_ctrl_if.sv | 32 +++
 rtl/ita_requant_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ita_requant_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ita_requant_ctrl_if.sv
// Shared requantizer types plus the tile-request / beat handshake bundle
// that connects the controller to its producer.
package ita_requant_pkg;
    typedef enum logic {
        Signed   = 1'b0,
        Unsigned = 1'b1
    } requant_mode_e;

    typedef logic [7:0] requant_const_t;
endpackage

interface ita_requant_ctrl_if #(
    parameter int SW    = 2,
    parameter int LEN_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [SW-1:0]    req_stage;
    logic [LEN_W-1:0] req_len;
    logic             beat_valid;
    logic             beat_ready;

    modport master (
        output req_valid, req_stage, req_len, beat_valid,
        input  req_ready, beat_ready
    );

    modport slave (
        input  req_valid, req_stage, req_len, beat_valid,
        output req_ready, beat_ready
    );
endinterface

// File: rtl/ita_requant_ctrl.sv
// Tile sequencer for the ITA requantizer: latches per-stage constants, issues
// credit-gated calc enables and tags the output two cycles later.
module ita_requant_ctrl
    import ita_requant_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int LEN_W      = 16,
    parameter int CREDITS    = 4,
    localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int CW        = $clog2(CREDITS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_we_i,
    input  logic [SW-1:0]        cfg_addr_i,
    input  requant_mode_e        cfg_mode_i,
    input  requant_const_t       cfg_mult_i,
    input  requant_const_t       cfg_shift_i,
    ita_requant_ctrl_if.slave    bus,
    output requant_mode_e        mode_o,
    output requant_const_t       eps_mult_o,
    output requant_const_t       right_shift_o,
    output logic                 calc_en_o,
    output logic                 calc_en_q_o,
    output logic                 out_valid_o,
    output logic                 out_last_o,
    input  logic                 credit_i,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 credit_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]    credit_q;
    logic             credit_err_q;
    logic             init_q;
    logic             en_q1, last_q1, valid_q2, last_q2;
    logic             done_q, done_d;
    logic             accept, issue, issue_last;
    logic             req_ready, beat_ready;

    requant_mode_e    mode_tab  [NUM_STAGES];
    requant_const_t   mult_tab  [NUM_STAGES];
    requant_const_t   shift_tab [NUM_STAGES];
    requant_mode_e    mode_q;
    requant_const_t   mult_q, shift_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = 1'b0;
        beat_ready = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Held low for the first cycle after reset so every output reads 0 there.
                req_ready = !init_q;
                if (bus.req_valid && req_ready) begin
                    accept = 1'b1;
                    if (bus.req_len != '0) begin
                        beat_cnt_d = bus.req_len;
                        state_d    = RUN;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            RUN: begin
                beat_ready = (credit_q != '0);
                issue      = bus.beat_valid && beat_ready;
                if (issue) begin
                    beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    if (beat_cnt_q == LEN_W'(1)) begin
                        issue_last = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // calc_en is already 0 here, so only the calc_en_q stage can still hold a beat.
                if (!en_q1) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            credit_q     <= CW'(CREDITS);
            credit_err_q <= 1'b0;
            init_q       <= 1'b1;
            en_q1        <= 1'b0;
            last_q1      <= 1'b0;
            valid_q2     <= 1'b0;
            last_q2      <= 1'b0;
            done_q       <= 1'b0;
            mode_q       <= Signed;
            mult_q       <= '0;
            shift_q      <= '0;
            // NOTE: the stage table is tiny and its cleared contents are visible to a request made before any write, so it is reset like plain state.
            for (int i = 0; i < NUM_STAGES; i++) begin
                mode_tab[i]  <= Signed;
                mult_tab[i]  <= '0;
                shift_tab[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            init_q     <= 1'b0;
            en_q1      <= issue;
            last_q1    <= issue_last;
            valid_q2   <= en_q1;
            last_q2    <= last_q1;
            done_q     <= done_d;

            if (cfg_we_i) begin
                mode_tab[cfg_addr_i]  <= cfg_mode_i;
                mult_tab[cfg_addr_i]  <= cfg_mult_i;
                shift_tab[cfg_addr_i] <= cfg_shift_i;
            end
            // Reads the pre-write entry when a write to the same stage lands this cycle.
            if (accept) begin
                mode_q  <= mode_tab[bus.req_stage];
                mult_q  <= mult_tab[bus.req_stage];
                shift_q <= shift_tab[bus.req_stage];
            end

            unique case ({credit_i, issue})
                2'b10: begin
                    if (credit_q == CW'(CREDITS)) credit_err_q <= 1'b1;
                    else                          credit_q     <= credit_q + CW'(1);
                end
                2'b01:   credit_q <= credit_q - CW'(1);
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.beat_ready = beat_ready;
    assign mode_o         = mode_q;
    assign eps_mult_o     = mult_q;
    assign right_shift_o  = shift_q;
    assign calc_en_o      = issue;
    assign calc_en_q_o    = en_q1;
    assign out_valid_o    = valid_q2;
    assign out_last_o     = last_q2;
    assign done_o         = done_q;
    assign busy_o         = (state_q != IDLE);
    assign credit_err_o   = credit_err_q;

endmodule

// File: tb/tb_ita_requant_ctrl.sv
// Directed bench for ita_requant_ctrl: cycle checks on the enables plus a
// scoreboard of expected output beats popped whenever out_valid_o is seen.
module tb_ita_requant_ctrl;
    import ita_requant_pkg::*;

    typedef struct {
        logic           last;
        requant_mode_e  mode;
        requant_const_t mult;
        requant_const_t shift;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           cfg_we;
    logic [1:0]     cfg_addr;
    requant_mode_e  cfg_mode;
    requant_const_t cfg_mult, cfg_shift;
    requant_mode_e  mode;
    requant_const_t eps_mult, right_shift;
    logic           calc_en, calc_en_q, out_valid, out_last;
    logic           credit, done, busy, credit_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    ita_requant_ctrl_if #(.SW(2), .LEN_W(16)) bus ();

    ita_requant_ctrl #(.NUM_STAGES(4), .LEN_W(16), .CREDITS(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_we_i      (cfg_we),
        .cfg_addr_i    (cfg_addr),
        .cfg_mode_i    (cfg_mode),
        .cfg_mult_i    (cfg_mult),
        .cfg_shift_i   (cfg_shift),
        .bus           (bus),
        .mode_o        (mode),
        .eps_mult_o    (eps_mult),
        .right_shift_o (right_shift),
        .calc_en_o     (calc_en),
        .calc_en_q_o   (calc_en_q),
        .out_valid_o   (out_valid),
        .out_last_o    (out_last),
        .credit_i      (credit),
        .done_o        (done),
        .busy_o        (busy),
        .credit_err_o  (credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {6'b0, mode, eps_mult, right_shift, bus.req_ready, bus.beat_ready,
                calc_en, calc_en_q, out_valid, out_last, done, busy, credit_err};
    endfunction

    task automatic push_tile(input int n, input bit tag_last, input requant_mode_e m,
                             input requant_const_t mult, input requant_const_t shift);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.last  = tag_last && (i == n - 1);
            e.mode  = m;
            e.mult  = mult;
            e.shift = shift;
            sb.push_back(e);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input requant_mode_e m,
                             input requant_const_t mult, input requant_const_t shift);
        cfg_we = 1'b1; cfg_addr = addr; cfg_mode = m; cfg_mult = mult; cfg_shift = shift;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic request(input logic [1:0] stage, input logic [15:0] len);
        bus.req_valid = 1'b1; bus.req_stage = stage; bus.req_len = len;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Returns sampled in the cycle where done is high (or the bound ran out).
    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(seen), 32'(1));
    endtask

    always @(negedge clk) begin
        if (out_last && !out_valid) check("last_without_valid", 32'(out_last), 32'(0));
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", 32'(out_valid), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                check("sb_last",  32'(out_last),    32'(mon_e.last));
                check("sb_mode",  32'(mode),        32'(mon_e.mode));
                check("sb_mult",  32'(eps_mult),    32'(mon_e.mult));
                check("sb_shift", 32'(right_shift), 32'(mon_e.shift));
            end
        end
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_mode = Signed; cfg_mult = '0; cfg_shift = '0;
        bus.req_valid = 1'b0; bus.req_stage = '0; bus.req_len = '0; bus.beat_valid = 1'b0;
        credit = 1'b0;

        // Reset: every output 0 in the first cycle after reset, ready one cycle later.
        tick(); tick();
        rst = 1'b0;
        sample(); check("reset_outputs", all_outs(), 32'(0));
        tick(); sample(); check("ready_after_reset", 32'(bus.req_ready), 32'(1));

        // Basic tile: stage 2, len 3, back-to-back beats, credits returned each beat.
        cfg_write(2'd2, Unsigned, 8'd77, 8'd10);
        push_tile(3, 1'b1, Unsigned, 8'd77, 8'd10);
        request(2'd2, 16'd3);
        bus.beat_valid = 1'b1; credit = 1'b1;
        sample();
        check("t1_calc_en_t0", 32'(calc_en), 32'(1));
        check("t1_mult", 32'(eps_mult), 32'(77));
        check("t1_shift", 32'(right_shift), 32'(10));
        check("t1_mode", 32'(mode), 32'(Unsigned));
        check("t1_busy", 32'(busy), 32'(1));
        check("t1_req_ready_run", 32'(bus.req_ready), 32'(0));
        check("t1_valid_t0", 32'(out_valid), 32'(0));
        tick(); sample();
        check("t1_calc_en_t1", 32'(calc_en), 32'(1));
        check("t1_calc_en_q_t1", 32'(calc_en_q), 32'(1));
        check("t1_valid_t1", 32'(out_valid), 32'(0));
        tick(); sample();
        check("t1_calc_en_t2", 32'(calc_en), 32'(1));
        check("t1_valid_t2", 32'(out_valid), 32'(1));
        check("t1_last_t2", 32'(out_last), 32'(0));
        tick(); bus.beat_valid = 1'b0; credit = 1'b0;
        sample();
        check("t1_calc_en_t3", 32'(calc_en), 32'(0));
        check("t1_valid_t3", 32'(out_valid), 32'(1));
        check("t1_done_t3", 32'(done), 32'(0));
        tick(); sample();
        check("t1_last_t4", 32'(out_last), 32'(1));
        check("t1_done_t4", 32'(done), 32'(0));
        tick(); sample();
        check("t1_done_t5", 32'(done), 32'(1));
        check("t1_busy_t5", 32'(busy), 32'(0));
        tick(); sample();
        check("t1_done_pulse", 32'(done), 32'(0));

        // Credit starvation: 4 beats issue, stall, then one beat per returned credit.
        cfg_write(2'd0, Signed, 8'd5, 8'd3);
        push_tile(6, 1'b1, Signed, 8'd5, 8'd3);
        request(2'd0, 16'd6);
        bus.beat_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(); check("t2_burst_issue", 32'(calc_en), 32'(1));
            tick();
        end
        sample();
        check("t2_starved_ready", 32'(bus.beat_ready), 32'(0));
        check("t2_starved_calc", 32'(calc_en), 32'(0));
        tick(); sample();
        check("t2_still_starved", 32'(calc_en), 32'(0));
        credit = 1'b1; tick(); credit = 1'b0;
        sample(); check("t2_issue5", 32'(calc_en), 32'(1));
        tick(); sample(); check("t2_starved_again", 32'(calc_en), 32'(0));
        credit = 1'b1; tick(); credit = 1'b0;
        sample(); check("t2_issue6", 32'(calc_en), 32'(1));
        tick(); bus.beat_valid = 1'b0;
        sample(); check("t2_done_early", 32'(done), 32'(0));
        tick(); sample(); check("t2_last_out", 32'(out_last), 32'(1));
        tick(); sample(); check("t2_done", 32'(done), 32'(1));
        credit = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        credit = 1'b0;

        // Table write during a running tile must not disturb its constants.
        cfg_write(2'd1, Signed, 8'd50, 8'd2);
        push_tile(3, 1'b1, Signed, 8'd50, 8'd2);
        request(2'd1, 16'd3);
        bus.beat_valid = 1'b1; credit = 1'b1;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_mode = Signed; cfg_mult = 8'd99; cfg_shift = 8'd2;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t3_issue", 32'(calc_en), 32'(1));
            check("t3_mult_held", 32'(eps_mult), 32'(50));
            tick(); cfg_we = 1'b0;
        end
        bus.beat_valid = 1'b0; credit = 1'b0;
        wait_done("t3_done");
        check("t3_mult_at_done", 32'(eps_mult), 32'(50));
        tick();
        push_tile(1, 1'b1, Signed, 8'd99, 8'd2);
        request(2'd1, 16'd1);
        bus.beat_valid = 1'b1; credit = 1'b1;
        sample();
        check("t3_new_mult", 32'(eps_mult), 32'(99));
        check("t3_new_issue", 32'(calc_en), 32'(1));
        tick(); bus.beat_valid = 1'b0; credit = 1'b0;
        wait_done("t3b_done");
        tick();

        // Zero-length tile: no issue, done two cycles after acceptance.
        request(2'd2, 16'd0);
        sample();
        check("t4_busy", 32'(busy), 32'(1));
        check("t4_no_issue", 32'(calc_en), 32'(0));
        check("t4_done_early", 32'(done), 32'(0));
        tick(); sample();
        check("t4_done", 32'(done), 32'(1));
        check("t4_idle", 32'(busy), 32'(0));
        check("t4_no_issue2", 32'(calc_en), 32'(0));
        tick(); sample();
        check("t4_done_pulse", 32'(done), 32'(0));

        // Reset after 2 of 5 beats: only the first beat reaches the output.
        push_tile(1, 1'b0, Signed, 8'd5, 8'd3);
        request(2'd0, 16'd5);
        bus.beat_valid = 1'b1;
        sample(); check("t5_issue1", 32'(calc_en), 32'(1));
        tick(); sample(); check("t5_issue2", 32'(calc_en), 32'(1));
        tick(); bus.beat_valid = 1'b0; rst = 1'b1;
        sample(); check("t5_first_out", 32'(out_valid), 32'(1));
        tick(); rst = 1'b0;
        sample(); check("t5_reset_outputs", all_outs(), 32'(0));
        tick(); sample();
        check("t5_ready", 32'(bus.req_ready), 32'(1));
        check("t5_no_done", 32'(done), 32'(0));
        push_tile(4, 1'b1, Signed, 8'd0, 8'd0);
        request(2'd0, 16'd4);
        bus.beat_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(); check("t5_full_credits", 32'(calc_en), 32'(1));
            tick();
        end
        bus.beat_valid = 1'b0;
        wait_done("t5_done");
        tick();
        credit = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        credit = 1'b0;

        // Excess credit returns: counter saturates at 4, error is sticky.
        sample(); check("t6_err_clear", 32'(credit_err), 32'(0));
        credit = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        credit = 1'b0;
        sample(); check("t6_err_set", 32'(credit_err), 32'(1));
        tick(); tick();
        sample(); check("t6_err_held", 32'(credit_err), 32'(1));
        push_tile(4, 1'b0, Signed, 8'd0, 8'd0);
        request(2'd0, 16'd5);
        bus.beat_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(); check("t6_issue", 32'(calc_en), 32'(1));
            tick();
        end
        sample(); check("t6_capped", 32'(bus.beat_ready), 32'(0));
        bus.beat_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        sample(); check("sb_drained", 32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
